// File: rtl/vec_mac_pkg.sv
// rtl/vec_mac_pkg.sv - shared FSM type, drain constant and saturating add for vec_mac_pipe
package vec_mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DRAIN_CYCLES = 3;

  // Widest accumulator sat_add can serve; callers sign-extend into it and keep the low ACC_WIDTH bits.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] value;
    logic                 ovf;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W:0] sum,
                                       input int acc_w,
                                       input logic saturate);
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] max_v;
    logic signed [SAT_MAX_W:0] min_v;
    sat_res_t r;
    one   = 1;
    max_v = (one <<< (acc_w - 1)) - one;
    min_v = -max_v - one;
    r.value = sum[SAT_MAX_W-1:0];
    r.ovf   = (sum > max_v) || (sum < min_v);
    if (r.ovf && saturate) begin
      r.value = (sum < min_v) ? min_v[SAT_MAX_W-1:0] : max_v[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// rtl/mac_lane_tree.sv - S1 lane multipliers and S2 lane-sum tree with per-stage valid bits
module mac_lane_tree #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int SUM_W      = 2*DATA_WIDTH + $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]   a,
  input  logic [LANES*DATA_WIDTH-1:0]   b,
  output logic                          s2_valid,
  output logic signed [SUM_W-1:0]       s2_sum
);

  localparam int PROD_W = 2*DATA_WIDTH;

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] s1_prod [LANES];
  logic                     s1_valid;
  logic signed [SUM_W-1:0]  lane_sum;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PROD_W'($signed(a[i*DATA_WIDTH +: DATA_WIDTH]))
                * PROD_W'($signed(b[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_W'(s1_prod[i]);
    end
  end

  // Data registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      s1_prod[i] <= prod_d[i];
    end
    s2_sum <= lane_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

endmodule

// File: rtl/vec_mac_pipe.sv
// rtl/vec_mac_pipe.sv - multi-lane signed accumulating MAC with ap_start/ap_done block control
module vec_mac_pipe
  import vec_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 16,
  parameter int SATURATE   = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        ap_ready,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic [ACC_WIDTH-1:0]        bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]        mac_result,
  output logic                        overflow
);

  localparam int SUM_W   = 2*DATA_WIDTH + $clog2(LANES);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t                       state;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH-1:0]         beat_cnt;
  logic [LEN_WIDTH-1:0]         beat_nxt;
  logic [DRAIN_W-1:0]           drain_cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         in_fire;
  logic                         start_fire;
  logic                         s2_valid;
  logic signed [SUM_W-1:0]      s2_sum;
  logic signed [ACC_WIDTH:0]    acc_sum;
  sat_res_t                     sat_res;
  logic                         unused_sat_value;

  assign in_fire    = in_valid & in_ready;
  assign start_fire = (state == IDLE) & ap_start;
  assign beat_nxt   = beat_cnt + LEN_WIDTH'(1);

  mac_lane_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SUM_W      (SUM_W)
  ) u_lane_tree (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .in_valid (in_fire),
    .a        (a),
    .b        (b),
    .s2_valid (s2_valid),
    .s2_sum   (s2_sum)
  );

  assign acc_sum = (ACC_WIDTH+1)'(s2_sum) + (ACC_WIDTH+1)'(acc);
  assign sat_res = sat_add((SAT_MAX_W+1)'(acc_sum), ACC_WIDTH, SATURATE != 0);
  assign unused_sat_value = ^sat_res.value;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (start_fire) begin
      acc      <= $signed(bias);
      overflow <= 1'b0;
    end else if (s2_valid) begin
      acc      <= sat_res.value[ACC_WIDTH-1:0];
      overflow <= overflow | sat_res.ovf;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      ap_idle    <= 1'b1;
      ap_done    <= 1'b0;
      ap_ready   <= 1'b0;
      in_ready   <= 1'b0;
      mac_result <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            len_q    <= len;
            beat_cnt <= '0;
            ap_idle  <= 1'b0;
            if (len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              // Empty job gets one extra drain cycle so it matches a one-beat job's start-to-done latency.
              state     <= DRAIN;
              drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            beat_cnt <= beat_nxt;
            if (beat_nxt == len_q) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= DONE;
            ap_done    <= 1'b1;
            ap_ready   <= 1'b1;
            mac_result <= acc;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          ap_idle <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
